sqrt_seq: RTL

Parametrised, multi-cycle integer square-root unit with valid/ready handshakes on input and output. It computes floor(sqrt(x)) for an unsigned WIDTH-bit operand using the non-restoring algorithm, resolving one root bit per clock. Optionally it also returns the exact remainder. It serves calculator and ALU-extension paths where a fully unrolled combinational root is too deep for timing.

---
 rtl/sqrt_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sqrt_seq.sv
// Sequential non-restoring integer square root: floor(sqrt(in_data)), one root bit per clock.
// Define SQRT_REM_EN to add the out_rem port and the remainder correction logic.
module sqrt_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root,
  output logic               busy
`ifdef SQRT_REM_EN
  ,
  output logic [WIDTH/2:0]   out_rem
`endif
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [N-1:0]          q_q, q_d;
  logic signed [N+1:0]   r_q, r_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N-1:0]          root_q, root_d;

  logic signed [N+1:0]   l_op, t_op, r_new;
  logic [N-1:0]          q_new;
  logic                  accept, last, load;

  // One iteration: shift two radicand bits in, then add or subtract the trial term by sign of r.
  always_comb begin
    l_op  = {r_q[N-1:0], a_q[WIDTH-1 -: 2]};
    t_op  = {q_q, r_q[N+1], 1'b1};
    r_new = r_q[N+1] ? (l_op + t_op) : (l_op - t_op);
    q_new = {q_q[N-2:0], ~r_new[N+1]};
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (state_q == BUSY) && (cnt_q == CW'(N - 1));
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_root  = root_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      BUSY: begin
        r_d   = r_new;
        q_d   = q_new;
        a_d   = a_q << 2;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          root_d  = q_new;
        end
      end
      DONE: begin
        if (accept)         load    = 1'b1;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = BUSY;
      a_d     = in_data;
      q_d     = '0;
      r_d     = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      root_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
    end
    a_q <= a_d;
    q_q <= q_d;
    r_q <= r_d;
  end

`ifdef SQRT_REM_EN
  logic [N:0] rem_q;

  // A negative final partial remainder is restored by adding back 2*root+1.
  function automatic logic [N:0] rem_fix(input logic signed [N+1:0] rn,
                                         input logic [N-1:0] qn);
    logic signed [N+1:0] s;
    s = rn[N+1] ? (rn + $signed({1'b0, qn, 1'b1})) : rn;
    return s[N:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset)     rem_q <= '0;
    else if (last) rem_q <= rem_fix(r_new, q_new);
  end

  assign out_rem = rem_q;
`endif

endmodule
